// File: rtl/pio_port_ctrl.sv
// pio_port_ctrl: 8-bit parallel port pin stage.
// Drives the pads from the output data register with per-bit enables taken
// from the direction register, synchronises pad inputs and raises a sticky
// flag when an input pin changes. It also runs a strobe/acknowledge output
// handshake that gives up after a bounded wait.
module pio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int STB_CYCLES  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dir_q,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             stb_n,
    input  logic             ack_n,
    output logic             busy,
    output logic             chg_irq,
    output logic             wr_ovr,
    output logic             tmo,
    input  logic             irq_clr
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_STROBE   = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_WAIT_REL = 3'd4;

    localparam logic [3:0] STB_LAST = 4'(STB_CYCLES - 1);
    localparam logic [7:0] TMO_LIM  = 8'(ACK_TIMEOUT);

    // Synchronisers and change-detect history
    logic [WIDTH-1:0] pad_meta_q;
    logic [WIDTH-1:0] sin_q;
    logic [WIDTH-1:0] sin_prev_q;
    logic             ack_meta_q;
    logic             ack_s_q;
    logic [1:0]       arm_cnt_q;
    logic             armed;

    // Handshake state
    logic [2:0]       state_q, state_d;
    logic [3:0]       stb_cnt_q, stb_cnt_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       tmo_inc;
    logic             tmo_set;

    // Output-side registers
    logic [WIDTH-1:0] pad_out_q, pad_out_d;
    logic [WIDTH-1:0] pad_oe_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             stb_n_q;

    // Sticky flags
    logic             chg_q, chg_d, chg_set;
    logic             ovr_q, ovr_d, ovr_set;
    logic             tmo_q, tmo_d;

    // The arm counter hides the synchroniser fill after reset, so the first
    // pad samples never look like a pin change.
    assign armed   = (arm_cnt_q == 2'd3);
    assign chg_set = armed && (|((sin_q ^ sin_prev_q) & ~dir_q));
    assign ovr_set = wr_en && (state_q != S_IDLE);
    assign tmo_inc = tmo_cnt_q + 8'd1;

    // A set in the same cycle as irq_clr wins so no event is lost.
    assign chg_d = chg_set | (chg_q & ~irq_clr);
    assign ovr_d = ovr_set | (ovr_q & ~irq_clr);
    assign tmo_d = tmo_set | (tmo_q & ~irq_clr);

    // Two-flop synchronisers for pad inputs and acknowledge, plus arm counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_meta_q <= '0;
            sin_q      <= '0;
            sin_prev_q <= '0;
            ack_meta_q <= 1'b1;
            ack_s_q    <= 1'b1;
            arm_cnt_q  <= 2'd0;
        end else begin
            pad_meta_q <= pad_in;
            sin_q      <= pad_meta_q;
            sin_prev_q <= sin_q;
            ack_meta_q <= ack_n;
            ack_s_q    <= ack_meta_q;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + 2'd1;
            end
        end
    end

    // Handshake next-state: data is latched only on acceptance in IDLE; a
    // timeout takes priority over acknowledge progress in the wait states.
    always_comb begin
        state_d   = state_q;
        stb_cnt_d = stb_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        pad_out_d = pad_out_q;
        tmo_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    pad_out_d = wr_data;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                stb_cnt_d = 4'd0;
                state_d   = S_STROBE;
            end
            S_STROBE: begin
                if (stb_cnt_q == STB_LAST) begin
                    tmo_cnt_d = 8'd0;
                    state_d   = S_WAIT_ACK;
                end else begin
                    stb_cnt_d = stb_cnt_q + 4'd1;
                end
            end
            S_WAIT_ACK, S_WAIT_REL: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_inc == TMO_LIM) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end else if ((state_q == S_WAIT_ACK) && !ack_s_q) begin
                    state_d = S_WAIT_REL;
                end else if ((state_q == S_WAIT_REL) && ack_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake state, counters and the registered strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            stb_cnt_q <= 4'd0;
            tmo_cnt_q <= 8'd0;
            stb_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            stb_cnt_q <= stb_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            stb_n_q   <= (state_d != S_STROBE);
        end
    end

    // Pad drive, output enables and readback mux
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pad_out_q <= '0;
            pad_oe_q  <= '0;
            rd_data_q <= '0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oe_q  <= dir_q;
            rd_data_q <= (dir_q & pad_out_q) | (~dir_q & sin_q);
        end
    end

    // Sticky status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_q <= 1'b0;
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
            ovr_q <= ovr_d;
            tmo_q <= tmo_d;
        end
    end

    assign pad_out = pad_out_q;
    assign pad_oe  = pad_oe_q;
    assign rd_data = rd_data_q;
    assign stb_n   = stb_n_q;
    assign busy    = (state_q != S_IDLE);
    assign chg_irq = chg_q;
    assign wr_ovr  = ovr_q;
    assign tmo     = tmo_q;

endmodule
